bet_entry_controller: RTL

Sequences keyboard bet entry for the roulette table. Consumes PS/2 set-2 scan-code strobes and strips break (F0) and extended (E0) prefixes. Maps make codes to bet opcodes through a scan-code lookup and lets the player adjust a wager, then confirm or cancel it. Each confirmed bet is checked against the player balance and issued to the game core over a valid/ready handshake. Per-round bet count is limited, and entry is locked while the wheel spins.

---
 rtl/roulette_pkg.sv | 33 +++
 rtl/scan_to_bet_lut.sv | 30 +++
 rtl/bet_entry_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/roulette_pkg.sv
// Shared roulette constants: bet opcodes, PS/2 set-2 scan codes and the bet-entry state type.
package roulette_pkg;

  localparam logic [5:0] BET_0       = 6'd0;
  localparam logic [5:0] BET_3       = 6'd3;
  localparam logic [5:0] BET_6       = 6'd6;
  localparam logic [5:0] BET_9       = 6'd9;
  localparam logic [5:0] BET_12      = 6'd12;
  localparam logic [5:0] BET_15      = 6'd15;
  localparam logic [5:0] BET_18      = 6'd18;
  localparam logic [5:0] BET_21      = 6'd21;
  localparam logic [5:0] BET_24      = 6'd24;
  localparam logic [5:0] BET_27      = 6'd27;
  localparam logic [5:0] BET_30      = 6'd30;
  localparam logic [5:0] BET_33      = 6'd33;
  localparam logic [5:0] BET_36      = 6'd36;
  localparam logic [5:0] BET_COL_TOP = 6'd31;
  localparam logic [5:0] BET_INVALID = 6'h3F;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_PLUS  = 8'h79;
  localparam logic [7:0] SC_MINUS = 8'h7B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2
  } state_e;

endpackage

// File: rtl/scan_to_bet_lut.sv
// Combinational PS/2 make-code to bet-opcode lookup; unmapped codes yield BET_INVALID.
module scan_to_bet_lut
  import roulette_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [5:0] opcode_o
);

  always_comb begin
    opcode_o = BET_INVALID;
    case (code_i)
      8'h0E: opcode_o = BET_0;
      8'h16: opcode_o = BET_3;
      8'h1E: opcode_o = BET_6;
      8'h26: opcode_o = BET_9;
      8'h25: opcode_o = BET_12;
      8'h2E: opcode_o = BET_15;
      8'h36: opcode_o = BET_18;
      8'h3D: opcode_o = BET_21;
      8'h3E: opcode_o = BET_24;
      8'h46: opcode_o = BET_27;
      8'h45: opcode_o = BET_30;
      8'h4E: opcode_o = BET_33;
      8'h55: opcode_o = BET_36;
      8'h66: opcode_o = BET_COL_TOP;
      default: opcode_o = BET_INVALID;
    endcase
  end

endmodule

// File: rtl/bet_entry_controller.sv
// Keyboard bet entry: prefix filtering, wager editing, balance check and valid/ready issue.
// Optional SELECT idle auto-cancel is enabled by defining BET_TIMEOUT_EN.
module bet_entry_controller
  import roulette_pkg::*;
#(
  parameter logic [7:0] MIN_BET  = 8'd1,
  parameter logic [7:0] MAX_BET  = 8'd100,
  parameter logic [7:0] BET_STEP = 8'd5,
  parameter logic [3:0] MAX_BETS = 4'd8
`ifdef BET_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic [7:0] balance,
  input  logic       spin_active,
  input  logic       round_clear,
  output logic       bet_valid,
  input  logic       bet_ready,
  output logic [5:0] bet_opcode,
  output logic [7:0] bet_amount,
  output logic       sel_active,
  output logic       reject,
  output logic       cancel,
  output logic [3:0] bet_count,
  output logic       round_full
);

  state_e     state_q, state_d;
  logic       brk_pend_q, brk_pend_d;
  logic [5:0] opcode_q, opcode_d;
  logic [7:0] amount_q, amount_d;
  logic [3:0] count_q, count_d;
  logic       reject_q, reject_d;
  logic       cancel_q, cancel_d;
`ifdef BET_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`endif

  logic [5:0] lut_opcode;
  logic       key_ev, key_opc, key_plus, key_minus, key_enter, key_esc, key_acc;
  logic [8:0] amt_plus, min_plus_step;

  scan_to_bet_lut u_lut (
    .code_i   (scan_code),
    .opcode_o (lut_opcode)
  );

  // The byte after a break prefix is swallowed; extended prefixes are simply dropped.
  assign key_ev    = scan_valid && !brk_pend_q && (scan_code != SC_BRK) && (scan_code != SC_EXT);
  assign key_opc   = key_ev && (lut_opcode != BET_INVALID);
  assign key_plus  = key_ev && (scan_code == SC_PLUS);
  assign key_minus = key_ev && (scan_code == SC_MINUS);
  assign key_enter = key_ev && (scan_code == SC_ENTER);
  assign key_esc   = key_ev && (scan_code == SC_ESC);
  assign key_acc   = key_opc || key_plus || key_minus || key_enter || key_esc;

  assign amt_plus      = {1'b0, amount_q} + {1'b0, BET_STEP};
  assign min_plus_step = {1'b0, MIN_BET} + {1'b0, BET_STEP};

  always_comb begin
    brk_pend_d = brk_pend_q;
    if (scan_valid) begin
      brk_pend_d = brk_pend_q ? 1'b0 : (scan_code == SC_BRK);
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    amount_d = amount_q;
    count_d  = count_q;
    reject_d = 1'b0;
    cancel_d = 1'b0;
`ifdef BET_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_opc && !spin_active && !round_full) begin
          state_d  = SELECT;
          opcode_d = lut_opcode;
          amount_d = MIN_BET;
`ifdef BET_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      SELECT: begin
`ifdef BET_TIMEOUT_EN
        tmo_d = key_acc ? '0 : tmo_q + 32'd1;
`endif
        // Spin lock outranks any key arriving in the same cycle.
        if (spin_active) begin
          cancel_d = 1'b1;
          state_d  = IDLE;
        end else if (key_opc) begin
          opcode_d = lut_opcode;
        end else if (key_plus) begin
          amount_d = (amt_plus > {1'b0, MAX_BET}) ? MAX_BET : amt_plus[7:0];
        end else if (key_minus) begin
          amount_d = ({1'b0, amount_q} >= min_plus_step) ? (amount_q - BET_STEP) : MIN_BET;
        end else if (key_enter) begin
          if (amount_q <= balance) state_d = ISSUE;
          else                     reject_d = 1'b1;
        end else if (key_esc) begin
          cancel_d = 1'b1;
          state_d  = IDLE;
        end
`ifdef BET_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          cancel_d = 1'b1;
          state_d  = IDLE;
        end
`endif
      end
      ISSUE: begin
        if (bet_ready) begin
          state_d = IDLE;
          if (count_q != MAX_BETS) count_d = count_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (round_clear) count_d = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      brk_pend_q <= 1'b0;
      opcode_q   <= '0;
      amount_q   <= '0;
      count_q    <= '0;
      reject_q   <= 1'b0;
      cancel_q   <= 1'b0;
`ifdef BET_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      brk_pend_q <= brk_pend_d;
      opcode_q   <= opcode_d;
      amount_q   <= amount_d;
      count_q    <= count_d;
      reject_q   <= reject_d;
      cancel_q   <= cancel_d;
`ifdef BET_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bet_valid  = (state_q == ISSUE);
  assign sel_active = (state_q == SELECT);
  assign bet_opcode = opcode_q;
  assign bet_amount = amount_q;
  assign reject     = reject_q;
  assign cancel     = cancel_q;
  assign bet_count  = count_q;
  assign round_full = (count_q == MAX_BETS);

endmodule
